// File: rtl/wb_stage.sv
// Write-back stage: holds the retiring instruction, extracts load data,
// drives the register-file write port, WB->EX bypass flags and retire count.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        m_valid,
    input  logic        m_RegWr,
    input  logic        m_MemtoReg,
    input  logic [2:0]  m_ld_type,
    input  logic [4:0]  m_addrW,
    input  logic [31:0] m_ALUout,
    input  logic [31:0] m_MemData,
    input  logic [4:0]  exRs,
    input  logic [4:0]  exRt,
    output logic        RegWr,
    output logic [4:0]  addrW,
    output logic [31:0] BusW,
    output logic        fwdA,
    output logic        fwdB,
    output logic        misalign,
    output logic [31:0] instret
);

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    logic        valid_q,    valid_d;
    logic        regwr_q,    regwr_d;
    logic        memtoreg_q, memtoreg_d;
    logic [2:0]  ld_type_q,  ld_type_d;
    logic [4:0]  addrw_q,    addrw_d;
    logic [31:0] aluout_q,   aluout_d;
    logic [31:0] memdata_q,  memdata_d;
    logic        misalign_q, misalign_d;
    logic [31:0] instret_q,  instret_d;

    logic        retire;
    logic        mis_cur;
    logic [31:0] load_data;

    // Big-endian word: offset 0 is the most significant byte.
    function automatic logic [31:0] extract_load(input logic [2:0]  ld,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = w[31:24];
            2'b01:   b = w[23:16];
            2'b10:   b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (ld)
            LD_LB:   extract_load = {{24{b[7]}}, b};
            LD_LBU:  extract_load = {24'd0, b};
            LD_LH:   extract_load = {{16{h[15]}}, h};
            LD_LHU:  extract_load = {16'd0, h};
            default: extract_load = w;
        endcase
    endfunction

    // Unknown load types behave as LW, so they need word alignment too.
    function automatic logic is_misaligned(input logic       mtr,
                                           input logic [2:0] ld,
                                           input logic [1:0] off);
        logic half;
        logic byte_ld;
        half    = (ld == LD_LH) || (ld == LD_LHU);
        byte_ld = (ld == LD_LB) || (ld == LD_LBU);
        if (!mtr)
            is_misaligned = 1'b0;
        else if (half)
            is_misaligned = off[0];
        else if (byte_ld)
            is_misaligned = 1'b0;
        else
            is_misaligned = (off != 2'b00);
    endfunction

    always_comb begin
        valid_d    = valid_q;
        regwr_d    = regwr_q;
        memtoreg_d = memtoreg_q;
        ld_type_d  = ld_type_q;
        addrw_d    = addrw_q;
        aluout_d   = aluout_q;
        memdata_d  = memdata_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d    = m_valid;
            regwr_d    = m_RegWr;
            memtoreg_d = m_MemtoReg;
            ld_type_d  = m_ld_type;
            addrw_d    = m_addrW;
            aluout_d   = m_ALUout;
            memdata_d  = m_MemData;
        end
    end

    // Retirement ignores flush: the instruction already in WB still leaves.
    assign retire  = valid_q & ~stall;
    assign mis_cur = is_misaligned(memtoreg_q, ld_type_q, aluout_q[1:0]);

    always_comb begin
        misalign_d = misalign_q | (retire & mis_cur);
        instret_d  = retire ? instret_q + 32'd1 : instret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwr_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            ld_type_q  <= 3'b000;
            addrw_q    <= 5'd0;
            aluout_q   <= 32'd0;
            memdata_q  <= 32'd0;
            misalign_q <= 1'b0;
            instret_q  <= 32'd0;
        end else begin
            valid_q    <= valid_d;
            regwr_q    <= regwr_d;
            memtoreg_q <= memtoreg_d;
            ld_type_q  <= ld_type_d;
            addrw_q    <= addrw_d;
            aluout_q   <= aluout_d;
            memdata_q  <= memdata_d;
            misalign_q <= misalign_d;
            instret_q  <= instret_d;
        end
    end

    assign load_data = extract_load(ld_type_q, aluout_q[1:0], memdata_q);

    // Stalled instructions keep writing: rewriting the same value is harmless.
    assign RegWr    = valid_q & regwr_q & (addrw_q != 5'd0) & ~mis_cur;
    assign addrW    = addrw_q;
    assign BusW     = memtoreg_q ? load_data : aluout_q;
    assign fwdA     = RegWr & (addrw_q == exRs);
    assign fwdB     = RegWr & (addrw_q == exRt);
    assign misalign = misalign_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load extraction, write gating, bypass flags,
// stall/flush behaviour, retire counting with wrap, and asynchronous reset.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        m_valid;
    logic        m_RegWr;
    logic        m_MemtoReg;
    logic [2:0]  m_ld_type;
    logic [4:0]  m_addrW;
    logic [31:0] m_ALUout;
    logic [31:0] m_MemData;
    logic [4:0]  exRs;
    logic [4:0]  exRt;
    logic        RegWr;
    logic [4:0]  addrW;
    logic [31:0] BusW;
    logic        fwdA;
    logic        fwdB;
    logic        misalign;
    logic [31:0] instret;

    int n_tests = 0;
    int n_fail  = 0;

    wb_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_RegWr    (m_RegWr),
        .m_MemtoReg (m_MemtoReg),
        .m_ld_type  (m_ld_type),
        .m_addrW    (m_addrW),
        .m_ALUout   (m_ALUout),
        .m_MemData  (m_MemData),
        .exRs       (exRs),
        .exRt       (exRt),
        .RegWr      (RegWr),
        .addrW      (addrW),
        .BusW       (BusW),
        .fwdA       (fwdA),
        .fwdB       (fwdB),
        .misalign   (misalign),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mtr, input logic [2:0] ld,
                         input logic [4:0] a, input logic [31:0] alu, input logic [31:0] mem);
        m_valid    = v;
        m_RegWr    = rw;
        m_MemtoReg = mtr;
        m_ld_type  = ld;
        m_addrW    = a;
        m_ALUout   = alu;
        m_MemData  = mem;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        exRs  = 5'd0;
        exRt  = 5'd0;
        idle();
        #3;
        check("rst_regwr",   {31'd0, RegWr},    32'd0);
        check("rst_addrw",   {27'd0, addrW},    32'd0);
        check("rst_busw",    BusW,              32'd0);
        check("rst_fwd",     {30'd0, fwdA, fwdB}, 32'd0);
        check("rst_mis",     {31'd0, misalign}, 32'd0);
        check("rst_instret", instret,           32'd0);
        #9 rst_n = 1'b1;

        // ALU write
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd5, 32'h12345678, 32'h0);
        step();
        idle();
        check("alu_regwr",   {31'd0, RegWr}, 32'd1);
        check("alu_addrw",   {27'd0, addrW}, 32'd5);
        check("alu_busw",    BusW,           32'h12345678);
        check("alu_ir0",     instret,        32'd0);
        step();
        check("alu_ir1",     instret,        32'd1);

        // Byte / half extraction from 0x80FF7F01
        drive(1'b1, 1'b1, 1'b1, 3'b001, 5'd3, 32'h100, 32'h80FF7F01);
        step();
        check("lb_off0",     BusW,           32'hFFFFFF80);
        check("lb_regwr",    {31'd0, RegWr}, 32'd1);
        drive(1'b1, 1'b1, 1'b1, 3'b010, 5'd3, 32'h100, 32'h80FF7F01);
        step();
        check("lbu_off0",    BusW,           32'h00000080);
        drive(1'b1, 1'b1, 1'b1, 3'b001, 5'd3, 32'h102, 32'h80FF7F01);
        step();
        check("lb_off2",     BusW,           32'h0000007F);
        drive(1'b1, 1'b1, 1'b1, 3'b011, 5'd3, 32'h100, 32'h80FF7F01);
        step();
        check("lh_off0",     BusW,           32'hFFFF80FF);
        drive(1'b1, 1'b1, 1'b1, 3'b100, 5'd3, 32'h100, 32'h80FF7F01);
        step();
        check("lhu_off0",    BusW,           32'h000080FF);
        drive(1'b1, 1'b1, 1'b1, 3'b011, 5'd3, 32'h102, 32'h80FF7F01);
        step();
        check("lh_off2",     BusW,           32'h00007F01);
        drive(1'b1, 1'b1, 1'b1, 3'b001, 5'd3, 32'h101, 32'h80FF7F01);
        step();
        check("lb_off1",     BusW,           32'hFFFFFFFF);
        drive(1'b1, 1'b1, 1'b1, 3'b010, 5'd3, 32'h103, 32'h80FF7F01);
        step();
        check("lbu_off3",    BusW,           32'h00000001);
        check("ld_ir",       instret,        32'd8);

        // Misaligned halfword
        drive(1'b1, 1'b1, 1'b1, 3'b011, 5'd4, 32'h101, 32'h11223344);
        step();
        check("mis_regwr",   {31'd0, RegWr},    32'd0);
        check("mis_pre",     {31'd0, misalign}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 3'b000, 5'd6, 32'h200, 32'hDEADBEEF);
        step();
        check("mis_set",     {31'd0, misalign}, 32'd1);
        check("mis_ir",      instret,           32'd10);
        check("lw_busw",     BusW,              32'hDEADBEEF);
        check("lw_regwr",    {31'd0, RegWr},    32'd1);

        // $zero destination and forwarding
        exRs = 5'd0;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd0, 32'h55, 32'h0);
        step();
        check("zero_regwr",  {31'd0, RegWr},    32'd0);
        check("zero_fwda",   {31'd0, fwdA},     32'd0);
        check("mis_sticky",  {31'd0, misalign}, 32'd1);
        exRs = 5'd9;
        exRt = 5'd9;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd9, 32'h99, 32'h0);
        step();
        check("fwd_ab",      {30'd0, fwdA, fwdB}, 32'd3);
        exRt = 5'd8;
        #1;
        check("fwd_b_miss",  {30'd0, fwdA, fwdB}, 32'd2);
        exRt = 5'd9;

        // Stall holds, then stall+flush bubbles without retiring
        stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd12, 32'hCC, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addrw", {27'd0, addrW}, 32'd9);
            check("stall_busw",  BusW,           32'h99);
            check("stall_regwr", {31'd0, RegWr}, 32'd1);
            check("stall_ir",    instret,        32'd12);
        end
        flush = 1'b1;
        step();
        check("sf_regwr",    {31'd0, RegWr}, 32'd0);
        check("sf_ir",       instret,        32'd12);
        stall = 1'b0;
        flush = 1'b0;
        idle();
        step();
        check("bubble_ir",   instret,        32'd12);

        // Counter wrap from a preloaded all-ones value
        force dut.instret_q = 32'hFFFFFFFF;
        #1;
        release dut.instret_q;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd3, 32'h1, 32'h0);
        step();
        check("wrap_pre",    instret,        32'hFFFFFFFF);
        idle();
        step();
        check("wrap_zero",   instret,        32'd0);

        // Flush alone still retires the occupant
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd2, 32'h7, 32'h0);
        step();
        check("fl_regwr0",   {31'd0, RegWr}, 32'd1);
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd10, 32'h8, 32'h0);
        step();
        check("fl_regwr1",   {31'd0, RegWr}, 32'd0);
        check("fl_ir",       instret,        32'd1);
        flush = 1'b0;

        // Asynchronous reset while a stalled instruction is held
        exRs = 5'd7;
        exRt = 5'd7;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd7, 32'hAA, 32'h0);
        step();
        check("ar_regwr0",   {31'd0, RegWr}, 32'd1);
        stall = 1'b1;
        idle();
        step();
        check("ar_ir_hold",  instret,        32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_regwr",    {31'd0, RegWr},      32'd0);
        check("ar_addrw",    {27'd0, addrW},      32'd0);
        check("ar_busw",     BusW,                32'd0);
        check("ar_fwd",      {30'd0, fwdA, fwdB}, 32'd0);
        check("ar_mis",      {31'd0, misalign},   32'd0);
        check("ar_ir",       instret,             32'd0);
        #2 rst_n = 1'b1;
        stall = 1'b0;
        step();
        check("post_regwr",  {31'd0, RegWr}, 32'd0);
        check("post_ir",     instret,        32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 clk  in  1  rising-edge clock shared with register file.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 stall  in  1  hold WB pipeline register.
REQ-004 flush  in  1  load bubble into WB register.
REQ-005 m_valid  in  1  MEM stage holds a real instruction.
REQ-006 m_RegWr  in  1  instruction writes a GPR.
REQ-007 m_MemtoReg  in  1  1 = load result, 0 = ALU result.
REQ-008 m_ld_type  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others treated as LW.
REQ-009 m_addrW  in  5  destination register.
REQ-010 m_ALUout  in  32  ALU result; bits [1:0] are the load byte offset.
REQ-011 m_MemData  in  32  raw aligned memory word, big-endian (offset 0 = bits[31:24]).
REQ-012 exRs, exRt  in  5 each  EX-stage source register numbers.
REQ-013 RegWr  out  1  register-file write enable.
REQ-014 addrW  out  5  register-file write address.
REQ-015 BusW  out  32  register-file write data.
REQ-016 fwdA, fwdB  out  1 each  WB result must bypass to EX operand A / B.
REQ-017 misalign  out  1  sticky: misaligned load seen.
REQ-018 instret  out  32  retired-instruction counter.

Function
REQ-019 WB register (valid, RegWr, MemtoReg, ld_type, addrW, ALUout, MemData) updates on posedge clk only.
REQ-020 Priority each edge: flush (valid<=0, other fields don't-care) > stall (hold all) > capture m_* fields.
REQ-021 Load extraction from stored word/offset: LW whole word; LB/LBU byte at offset (00 -> [31:24] … 11 -> [7:0]), sign-/zero-extended; LH/LHU half at offset[1] (0 -> [31:16], 1 -> [15:0]), sign-/zero-extended.
REQ-022 Misaligned load: MemtoReg=1 and (LW with offset!=00, or LH/LHU with offset[0]=1).
REQ-023 BusW = MemtoReg ? extracted load data : ALUout; combinational from WB register.
REQ-024 RegWr = valid & stored RegWr & (addrW!=0) & ~misaligned-current; combinational.
REQ-025 RegWr stays asserted while stalled (idempotent rewrite); no additional suppression.
REQ-026 fwdA = RegWr & (addrW==exRs); fwdB = RegWr & (addrW==exRt); combinational, zero latency.
REQ-027 misalign sets on the edge where a valid misaligned load leaves WB (valid & ~stall); clears only on reset.
REQ-028 Retire event = valid & ~stall at posedge; flush does not cancel retirement of the instruction already in WB.
REQ-029 instret increments by 1 per retire event, including suppressed-write and misaligned instructions; wraps 0xFFFFFFFF -> 0.
REQ-030 Simultaneous flush and stall: flush wins; instret still follows REQ-028 (no increment, since stall=1).

Reset
REQ-031 rst_n low asynchronously clears valid, all WB fields, misalign, and instret to 0.
REQ-032 During/after reset: RegWr=0, addrW=0, BusW=0, fwdA=fwdB=0, instret=0, misalign=0.
REQ-033 Reset asserted mid-stall discards the held instruction; no register-file write and no retire.

Verification
REQ-034 ALU write: m_valid=1, m_RegWr=1, m_MemtoReg=0, m_addrW=5, m_ALUout=0x12345678 -> next cycle RegWr=1, addrW=5, BusW=0x12345678; instret=1 after the following edge.
REQ-035 LB/LBU: MemData=0x80FF7F01, ALUout[1:0]=00 -> LB BusW=0xFFFFFF80, LBU BusW=0x00000080; offset 10 LB -> 0x0000007F.
REQ-036 LH offset 01 (misaligned): RegWr=0, misalign=1 after exit edge, instret increments; misalign remains 1 through later aligned loads.
REQ-037 $zero and forwarding: m_addrW=0 -> RegWr=0, fwdA=0 with exRs=0; m_addrW=9, exRs=9, exRt=9 -> fwdA=fwdB=1.
REQ-038 Stall/flush: stall=1 for 3 cycles holds outputs and instret; stall=1 & flush=1 -> valid=0 next cycle, instret unchanged; instret preloaded to 0xFFFFFFFF wraps to 0 on the next retire.
REQ-039 Async reset: drop rst_n between edges while valid -> all outputs 0 immediately, before the next clk edge.
